// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
//
// Memory-side responder for cache4way. It accepts one request at a time on
// the cache memory port and serves it from an internal word-addressed RAM
// after a fixed latency.
//   - A line refill (rdwr = 0) returns 2^WORD_OFFSET one-cycle ack beats,
//     separated by one idle cycle.
//   - A single-word write (rdwr = 1) returns one ack strobe, and the RAM
//     is updated on that same edge.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   req_cc2mem   request, held by the cache until it sees completion
//   adr_cc2mem   byte address (only the word-index bits are decoded)
//   rdwr_cc2mem  0 = line read, 1 = single-word write
//   dat_cc2mem   write data
//   ack_mem2cc   beat / write-done strobe
//   dat_mem2cc   beat data, zero when no beat is presented
//   word_mem2cc  word index of the current beat within the line
//   busy         high from accept until the controller is back in idle
module mem_burst_ctrl #(
  parameter int ADR_WIDTH      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_OFFSET    = 2,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int LATENCY        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_cc2mem,
  input  logic [ADR_WIDTH-1:0]   adr_cc2mem,
  input  logic                   rdwr_cc2mem,
  input  logic [DATA_WIDTH-1:0]  dat_cc2mem,
  output logic                   ack_mem2cc,
  output logic [DATA_WIDTH-1:0]  dat_mem2cc,
  output logic [WORD_OFFSET-1:0] word_mem2cc,
  output logic                   busy
);

  localparam int         DEPTH    = 1 << MEM_DEPTH_LOG2;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT,
    S_GAP,
    S_WRACK,
    S_DONE
  } state_t;

  state_t                    state_reg, state_next;
  logic [7:0]                cnt_reg, cnt_next;
  logic [WORD_OFFSET-1:0]    k_reg, k_next;
  logic [MEM_DEPTH_LOG2-1:0] idx_reg;
  logic                      rdwr_reg;
  logic [DATA_WIDTH-1:0]     wdata_reg;

  logic                      ack_reg;
  logic [DATA_WIDTH-1:0]     dat_reg;
  logic [WORD_OFFSET-1:0]    word_reg;
  logic                      busy_reg;

  logic [MEM_DEPTH_LOG2-1:0] rd_idx;
  logic                      wr_en;
  logic                      unused_adr_bits;

  // Address bits above the RAM depth and the byte-lane bits are ignored,
  // so the address space aliases.
  assign unused_adr_bits = ^{adr_cc2mem[ADR_WIDTH-1:MEM_DEPTH_LOG2+2], adr_cc2mem[1:0]};

  // The RAM holds (value XOR word index). Block RAM powers up to all zeros,
  // so every word initially reads back as its own index without any
  // preload. The reset does not touch the RAM.
  logic [DATA_WIDTH-1:0] delta_mem [DEPTH];

  // Beat address: line base from the latched index, low bits from k. Both
  // come from registers that are stable in the cycle before each beat.
  assign rd_idx = {idx_reg[MEM_DEPTH_LOG2-1:WORD_OFFSET], k_reg};

  // A write is committed only on the edge that enters WRACK. If reset is
  // asserted on that edge, the write is dropped.
  assign wr_en = rst && (state_next == S_WRACK);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      delta_mem[idx_reg] <= wdata_reg ^ DATA_WIDTH'(idx_reg);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    k_next     = k_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_cc2mem) begin
          state_next = S_WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = rdwr_reg ? S_WRACK : S_BEAT;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      // k has already advanced past the beat being presented. A wrap to 0
      // means the last word of the line is on the bus now.
      S_BEAT:  state_next = (k_reg == '0) ? S_DONE : S_GAP;
      S_GAP:   state_next = S_BEAT;
      S_WRACK: state_next = S_DONE;
      S_DONE: begin
        if (!req_cc2mem) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (state_next == S_BEAT) begin
      k_next = k_reg + WORD_OFFSET'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      k_reg     <= '0;
      idx_reg   <= '0;
      rdwr_reg  <= 1'b0;
      wdata_reg <= '0;
      ack_reg   <= 1'b0;
      dat_reg   <= '0;
      word_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      k_reg     <= k_next;
      if (state_reg == S_IDLE && req_cc2mem) begin
        idx_reg   <= adr_cc2mem[MEM_DEPTH_LOG2+1:2];
        rdwr_reg  <= rdwr_cc2mem;
        wdata_reg <= dat_cc2mem;
      end
      // Outputs are registered from the next state, so each strobe lines
      // up with the edge that enters BEAT or WRACK.
      ack_reg  <= (state_next == S_BEAT) || (state_next == S_WRACK);
      dat_reg  <= (state_next == S_BEAT) ? (delta_mem[rd_idx] ^ DATA_WIDTH'(rd_idx)) : '0;
      word_reg <= (state_next == S_BEAT) ? k_reg : '0;
      busy_reg <= (state_next != S_IDLE);
    end
  end

  assign ack_mem2cc  = ack_reg;
  assign dat_mem2cc  = dat_reg;
  assign word_mem2cc = word_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl
//
// Scoreboard bench for mem_burst_ctrl. When a request is issued, the bench
// pushes the expected ack cycle, data and word index of every strobe it
// should cause. A negedge monitor pops and compares each ack as it arrives.
// It also flags acks that arrive with nothing pending and strobes that never
// show up.
`timescale 1ns/1ps
module tb_mem_burst_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] adr;
  logic        rdwr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] dat;
  logic [1:0]  word;
  logic        busy;

  always #5 clk = ~clk;

  mem_burst_ctrl #(
    .ADR_WIDTH      (32),
    .DATA_WIDTH     (32),
    .WORD_OFFSET    (2),
    .MEM_DEPTH_LOG2 (10),
    .LATENCY        (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_cc2mem  (req),
    .adr_cc2mem  (adr),
    .rdwr_cc2mem (rdwr),
    .dat_cc2mem  (wdat),
    .ack_mem2cc  (ack),
    .dat_mem2cc  (dat),
    .word_mem2cc (word),
    .busy        (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [31:0] dat;
    logic [1:0]  word;
    bit          wr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_mem [1024];
  int          n_checks = 0;
  int          n_errors = 0;
  int          acc_cyc;
  int          t0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=0x%0h want=0x%0h cycle=%0d", tag, got, want, cyc);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (ack) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_ack", 64'(ack), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("ack_cycle", 64'(cyc), 64'(mon_e.at));
          if (!mon_e.wr) begin
            check_val("beat_dat", 64'(dat), 64'(mon_e.dat));
            check_val("beat_word", 64'(word), 64'(mon_e.word));
          end
          $display("ack cycle=%0d wr=%0d dat=0x%08h word=%0d", cyc, mon_e.wr, dat, word);
        end
      end else begin
        check_val("dat_without_ack", 64'(dat), 64'd0);
        if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
          check_val("missed_ack", 64'(cyc), 64'(exp_q[0].at));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drive a request in the current cycle. The DUT must be idle, so the
  // accept lands on the next rising edge.
  task automatic launch(input logic [31:0] a, input logic w, input logic [31:0] d);
    int idx;
    int base;
    idx  = int'(a[11:2]);
    base = idx & ~3;
    req  = 1'b1;
    adr  = a;
    rdwr = w;
    wdat = d;
    acc_cyc = cyc + 1;
    if (w) begin
      exp_q.push_back('{acc_cyc + LAT, 32'h0, 2'd0, 1'b1});
      model_mem[idx] = d;
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back('{acc_cyc + LAT + 2 * k, model_mem[base + k], 2'(k), 1'b0});
      end
    end
    $display("issue cycle=%0d adr=0x%08h wr=%0d dat=0x%08h", acc_cyc, a, w, d);
  endtask

  task automatic wait_beats(input int left);
    int budget;
    budget = 64;
    while (exp_q.size() > left && budget > 0) begin
      tick();
      budget--;
    end
    if (exp_q.size() > left) begin
      check_val("timeout_beats", 64'(exp_q.size()), 64'(left));
      exp_q.delete();
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 16;
    while (busy && budget > 0) begin
      tick();
      budget--;
    end
    check_val("busy_fall", 64'(busy), 64'd0);
  endtask

  // Hold req until the last strobe, then drop it and wait for idle.
  task automatic finish_txn();
    wait_beats(0);
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'(i);
    rst  = 1'b0;
    req  = 1'b1;
    adr  = 32'h0000_0014;
    rdwr = 1'b0;
    wdat = 32'h0;

    // Reset held with a pending request.
    for (int r = 0; r < 2; r++) begin
      tick();
      check_val("rst_ack", 64'(ack), 64'd0);
      check_val("rst_dat", 64'(dat), 64'd0);
      check_val("rst_word", 64'(word), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
    end

    // Refill of 0x14 is accepted on the edge right after reset is released.
    rst = 1'b1;
    launch(32'h0000_0014, 1'b0, 32'h0);
    tick();
    check_val("busy_after_accept", 64'(busy), 64'd1);
    finish_txn();

    // Write, then refill the same line.
    launch(32'h0000_0108, 1'b1, 32'hDEAD_BEEF);
    tick();
    check_val("busy_write", 64'(busy), 64'd1);
    finish_txn();
    launch(32'h0000_0100, 1'b0, 32'h0);
    finish_txn();

    // Request held long after the burst must not re-trigger.
    launch(32'h0000_0040, 1'b0, 32'h0);
    wait_beats(0);
    repeat (10) begin
      tick();
      check_val("busy_held", 64'(busy), 64'd1);
    end
    req = 1'b0;
    tick();
    check_val("busy_drop", 64'(busy), 64'd0);

    // Reset right after beat 1.
    launch(32'h0000_0200, 1'b0, 32'h0);
    wait_beats(2);
    rst = 1'b0;
    req = 1'b0;
    exp_q.delete();
    tick();
    check_val("midrst_ack", 64'(ack), 64'd0);
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_word", 64'(word), 64'd0);
    tick();
    rst = 1'b1;
    launch(32'h0000_0FF0, 1'b0, 32'h0);
    finish_txn();

    // Aliased refill, then back-to-back write and readback at minimum turnaround.
    launch(32'h0000_1010, 1'b0, 32'h0);
    t0 = acc_cyc;
    finish_txn();
    launch(32'h0000_0000, 1'b1, 32'h1234_5678);
    check_val("turnaround_read", 64'(acc_cyc - t0), 64'(LAT + 9));
    t0 = acc_cyc;
    finish_txn();
    launch(32'h0000_0000, 1'b0, 32'h0);
    check_val("turnaround_write", 64'(acc_cyc - t0), 64'(LAT + 3));
    finish_txn();

    tick();
    tick();
    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
